// File: rtl/tone_gen_if.sv
// Tone generator control/status bundle: the controller drives the request
// side (start/stop and tone settings), the tone generator returns the
// buzzer output and status pulses.
interface tone_gen_if #(
   parameter int CNT_W  = 32,
   parameter int DUTY_W = 8,
   parameter int LEN_W  = 16
) ();
   logic              start;
   logic              stop;
   logic [1:0]        mode;
   logic [CNT_W-1:0]  divnum;
   logic [DUTY_W-1:0] duty;
   logic [LEN_W-1:0]  burst_len;
   logic [LEN_W-1:0]  gap_len;
   logic              beep;
   logic              busy;
   logic              done;
   logic              period_tick;

   modport master (
      output start, stop, mode, divnum, duty, burst_len, gap_len,
      input  beep, busy, done, period_tick
   );

   modport slave (
      input  start, stop, mode, divnum, duty, burst_len, gap_len,
      output beep, busy, done, period_tick
   );
endinterface

// File: rtl/tone_gen.sv
// tone_gen: programmable-duty tone generator for the buzzer path.
// Modes: continuous, single burst, repeating burst/gap. Divisor and duty
// threshold are taken only at period boundaries, so a running tone never
// glitches when the settings change underneath it.
module tone_gen #(
   parameter int CNT_W  = 32,
   parameter int DUTY_W = 8,
   parameter int LEN_W  = 16
) (
   input logic       clk,
   input logic       rst_n,
   tone_gen_if.slave bus
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_TONE = 2'd1,
      ST_GAP  = 2'd2
   } state_t;

   // A period shorter than two cycles cannot hold both a low and a high phase.
   function automatic logic [CNT_W-1:0] clamp_div(input logic [CNT_W-1:0] d);
      logic [CNT_W-1:0] r;
      if (d < CNT_W'(2)) begin
         r = CNT_W'(2);
      end else begin
         r = d;
      end
      return r;
   endfunction

   // A burst always contains at least one period.
   function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] l);
      logic [LEN_W-1:0] r;
      if (l == LEN_W'(0)) begin
         r = LEN_W'(1);
      end else begin
         r = l;
      end
      return r;
   endfunction

   state_t                    state_r, state_nxt_s;
   logic [CNT_W-1:0]          cnt_r, cnt_nxt_s;
   logic [LEN_W-1:0]          per_cnt_r, per_nxt_s;
   logic [CNT_W-1:0]          div_l_r, th_l_r;
   logic [1:0]                mode_l_r;
   logic [LEN_W-1:0]          blen_l_r, glen_l_r;
   logic                      beep_r, busy_r, done_r, tick_r;

   logic [CNT_W-1:0]          div_s, th_s;
   logic [CNT_W+DUTY_W-1:0]   prod_s;
   logic                      boundary_s, blen_end_s, glen_end_s;
   logic                      relatch_s, latch_cfg_s;
   logic                      done_nxt_s, beep_nxt_s, tick_nxt_s, busy_nxt_s;

   // Candidate divisor/threshold from the live inputs, plus period-end flags.
   always_comb begin
      div_s      = clamp_div(bus.divnum);
      prod_s     = (CNT_W+DUTY_W)'(div_s) * (CNT_W+DUTY_W)'(bus.duty);
      th_s       = CNT_W'(prod_s >> DUTY_W);
      boundary_s = (cnt_r == (div_l_r - CNT_W'(1)));
      blen_end_s = (per_cnt_r == (blen_l_r - LEN_W'(1)));
      glen_end_s = (per_cnt_r == (glen_l_r - LEN_W'(1)));
   end

   // Next state, counters and pulse requests; stop takes priority over start.
   always_comb begin
      state_nxt_s = state_r;
      cnt_nxt_s   = cnt_r;
      per_nxt_s   = per_cnt_r;
      relatch_s   = 1'b0;
      latch_cfg_s = 1'b0;
      done_nxt_s  = 1'b0;
      if (bus.stop) begin
         state_nxt_s = ST_IDLE;
         cnt_nxt_s   = CNT_W'(0);
         per_nxt_s   = LEN_W'(0);
      end else if (bus.start) begin
         state_nxt_s = ST_TONE;
         cnt_nxt_s   = CNT_W'(0);
         per_nxt_s   = LEN_W'(0);
         latch_cfg_s = 1'b1;
         relatch_s   = 1'b1;
      end else begin
         case (state_r)
            ST_IDLE: begin
               cnt_nxt_s = CNT_W'(0);
            end
            ST_TONE: begin
               if (boundary_s) begin
                  cnt_nxt_s = CNT_W'(0);
                  relatch_s = 1'b1;
                  if (blen_end_s) begin
                     per_nxt_s = LEN_W'(0);
                     case (mode_l_r)
                        2'd1: begin
                           state_nxt_s = ST_IDLE;
                           done_nxt_s  = 1'b1;
                        end
                        2'd2: begin
                           if (glen_l_r != LEN_W'(0)) begin
                              state_nxt_s = ST_GAP;
                           end else begin
                              state_nxt_s = ST_TONE;
                           end
                        end
                        default: begin
                           state_nxt_s = ST_TONE;
                        end
                     endcase
                  end else begin
                     per_nxt_s = per_cnt_r + LEN_W'(1);
                  end
               end else begin
                  cnt_nxt_s = cnt_r + CNT_W'(1);
               end
            end
            ST_GAP: begin
               if (boundary_s) begin
                  cnt_nxt_s = CNT_W'(0);
                  relatch_s = 1'b1;
                  if (glen_end_s) begin
                     state_nxt_s = ST_TONE;
                     per_nxt_s   = LEN_W'(0);
                  end else begin
                     per_nxt_s = per_cnt_r + LEN_W'(1);
                  end
               end else begin
                  cnt_nxt_s = cnt_r + CNT_W'(1);
               end
            end
            default: begin
               state_nxt_s = ST_IDLE;
               cnt_nxt_s   = CNT_W'(0);
               per_nxt_s   = LEN_W'(0);
            end
         endcase
      end
   end

   // Output values for the next cycle; beep lags the counter by one cycle.
   always_comb begin
      busy_nxt_s = (state_nxt_s != ST_IDLE);
      if (!bus.stop && (state_r == ST_TONE) && (cnt_r >= (div_l_r - th_l_r))) begin
         beep_nxt_s = 1'b1;
      end else begin
         beep_nxt_s = 1'b0;
      end
      if (!bus.stop && (state_r != ST_IDLE) && boundary_s) begin
         tick_nxt_s = 1'b1;
      end else begin
         tick_nxt_s = 1'b0;
      end
   end

   // State and counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r   <= ST_IDLE;
         cnt_r     <= CNT_W'(0);
         per_cnt_r <= LEN_W'(0);
      end else begin
         state_r   <= state_nxt_s;
         cnt_r     <= cnt_nxt_s;
         per_cnt_r <= per_nxt_s;
      end
   end

   // Mode/lengths held from start; divisor/threshold refreshed at boundaries.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mode_l_r <= 2'd0;
         blen_l_r <= LEN_W'(0);
         glen_l_r <= LEN_W'(0);
         div_l_r  <= CNT_W'(0);
         th_l_r   <= CNT_W'(0);
      end else begin
         if (latch_cfg_s) begin
            mode_l_r <= bus.mode;
            blen_l_r <= clamp_len(bus.burst_len);
            glen_l_r <= bus.gap_len;
         end else begin
            mode_l_r <= mode_l_r;
            blen_l_r <= blen_l_r;
            glen_l_r <= glen_l_r;
         end
         if (relatch_s) begin
            div_l_r <= div_s;
            th_l_r  <= th_s;
         end else begin
            div_l_r <= div_l_r;
            th_l_r  <= th_l_r;
         end
      end
   end

   // Registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         beep_r <= 1'b0;
         busy_r <= 1'b0;
         done_r <= 1'b0;
         tick_r <= 1'b0;
      end else begin
         beep_r <= beep_nxt_s;
         busy_r <= busy_nxt_s;
         done_r <= done_nxt_s;
         tick_r <= tick_nxt_s;
      end
   end

   assign bus.beep        = beep_r;
   assign bus.busy        = busy_r;
   assign bus.done        = done_r;
   assign bus.period_tick = tick_r;

endmodule

// File: tb/tb_tone_gen.sv
// Testbench for tone_gen: directed scenarios plus randomized settings, each
// checked cycle by cycle against a period-level model of the expected tone.
module tb_tone_gen;

   localparam int CNT_W  = 32;
   localparam int DUTY_W = 8;
   localparam int LEN_W  = 16;

   logic clk;
   logic rst_n;
   int   n_tests;
   int   n_fail;

   // Expected per-cycle activity after a start: tone/gap, high phase, period end.
   bit   m_tone[$];
   bit   m_hi[$];
   bit   m_last[$];
   bit   m_ends;

   tone_gen_if #(.CNT_W(CNT_W), .DUTY_W(DUTY_W), .LEN_W(LEN_W)) bif ();

   tone_gen #(.CNT_W(CNT_W), .DUTY_W(DUTY_W), .LEN_W(LEN_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bif)
   );

   // Free-running clock, 10 time units per cycle.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input int k, input logic obs, input logic exp_v);
      n_tests++;
      assert (obs === exp_v) else begin
         n_fail++;
         $error("FAIL %s cyc=%0d observed=%0b expected=%0b", tag, k, obs, exp_v);
      end
   endtask

   task automatic chk_idle(input string tag, input int k);
      chk({tag, "_beep"}, k, bif.beep, 1'b0);
      chk({tag, "_busy"}, k, bif.busy, 1'b0);
      chk({tag, "_done"}, k, bif.done, 1'b0);
      chk({tag, "_tick"}, k, bif.period_tick, 1'b0);
   endtask

   // Lay out the tone period by period: low phase of div-th cycles, then th high.
   // duty0 applies to the first period, duty1 to every later one.
   task automatic build_model(input int mode, input int divnum, input int duty0,
                              input int duty1, input int blen, input int glen,
                              input int ncyc);
      int d, th, p, pc, bl;
      bit in_tone;
      m_tone.delete();
      m_hi.delete();
      m_last.delete();
      m_ends  = 1'b0;
      d       = (divnum < 2) ? 2 : divnum;
      bl      = (blen < 1) ? 1 : blen;
      p       = 0;
      pc      = 0;
      in_tone = 1'b1;
      while ((m_tone.size() < ncyc + 1) && !m_ends) begin
         th = (d * ((p == 0) ? duty0 : duty1)) / 256;
         for (int c = 0; c < d; c++) begin
            m_tone.push_back(in_tone);
            m_hi.push_back(in_tone && (c >= d - th));
            m_last.push_back(c == d - 1);
         end
         p++;
         pc++;
         if (in_tone) begin
            if (pc == bl) begin
               pc = 0;
               if (mode == 1) m_ends = 1'b1;
               else if (mode == 2 && glen > 0) in_tone = 1'b0;
            end
         end else begin
            if (pc == glen) begin
               pc      = 0;
               in_tone = 1'b1;
            end
         end
      end
   endtask

   task automatic set_cfg(input int mode, input int divnum, input int duty,
                          input int blen, input int glen);
      bif.mode      = 2'(mode);
      bif.divnum    = CNT_W'(divnum);
      bif.duty      = DUTY_W'(duty);
      bif.burst_len = LEN_W'(blen);
      bif.gap_len   = LEN_W'(glen);
   endtask

   // Start pulse; returns 1 unit after the edge, i.e. in cycle 1 of the tone.
   task automatic do_start();
      bif.start = 1'b1;
      @(posedge clk); #1;
      bif.start = 1'b0;
   endtask

   task automatic do_stop();
      bif.stop = 1'b1;
      @(posedge clk); #1;
      bif.stop = 1'b0;
      repeat (2) begin
         @(posedge clk); #1;
      end
   endtask

   // Compare cycles 1..ncyc against the model; optionally change duty in cycle chg_k.
   task automatic run_check(input string tag, input int ncyc, input int chg_k, input int chg_duty);
      int  sz;
      bit  e_busy, e_beep, e_tick, e_done;
      sz = m_tone.size();
      for (int k = 1; k <= ncyc; k++) begin
         e_busy = m_ends ? (k <= sz) : 1'b1;
         e_beep = (k >= 2 && k - 2 < sz) ? m_hi[k-2] : 1'b0;
         e_tick = (k >= 2 && k - 2 < sz) ? m_last[k-2] : 1'b0;
         e_done = m_ends && (k == sz + 1);
         chk({tag, "_beep"}, k, bif.beep, e_beep);
         chk({tag, "_busy"}, k, bif.busy, e_busy);
         chk({tag, "_done"}, k, bif.done, e_done);
         chk({tag, "_tick"}, k, bif.period_tick, e_tick);
         if (k == chg_k) bif.duty = DUTY_W'(chg_duty);
         @(posedge clk); #1;
      end
   endtask

   initial begin
      int md, dv, dt, bl, gl;
      n_tests   = 0;
      n_fail    = 0;
      rst_n     = 1'b0;
      bif.start = 1'b0;
      bif.stop  = 1'b0;
      set_cfg(0, 0, 0, 0, 0);
      #2;
      chk_idle("reset", 0);
      #20 rst_n = 1'b1;
      @(posedge clk); #1;
      for (int k = 1; k <= 3; k++) begin
         chk_idle("post_reset", k);
         @(posedge clk); #1;
      end

      // Continuous 50 % tone: 5 low / 5 high.
      set_cfg(0, 10, 128, 1, 0);
      do_start();
      build_model(0, 10, 128, 128, 1, 0, 45);
      run_check("m0_div10", 45, 0, 0);
      do_stop();

      // Duty change mid-period takes effect from the next period.
      set_cfg(0, 8, 64, 1, 0);
      do_start();
      build_model(0, 8, 64, 192, 1, 0, 40);
      run_check("m0_dutychg", 40, 3, 192);
      do_stop();

      // Single burst of three periods.
      set_cfg(1, 4, 128, 3, 0);
      do_start();
      build_model(1, 4, 128, 128, 3, 0, 20);
      run_check("m1_burst3", 20, 0, 0);

      // Burst/gap pattern, then stop in the middle of a gap.
      set_cfg(2, 4, 128, 2, 1);
      do_start();
      build_model(2, 4, 128, 128, 2, 1, 9);
      run_check("m2_pattern", 9, 0, 0);
      bif.stop = 1'b1;
      @(posedge clk); #1;
      bif.stop = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         chk_idle("m2_stop", k);
         @(posedge clk); #1;
      end

      // Start and stop together: stop wins.
      bif.start = 1'b1;
      bif.stop  = 1'b1;
      @(posedge clk); #1;
      bif.start = 1'b0;
      bif.stop  = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         chk_idle("start_stop", k);
         @(posedge clk); #1;
      end

      // Divisor 0 and 1 act as 2.
      set_cfg(0, 0, 128, 1, 0);
      do_start();
      build_model(0, 0, 128, 128, 1, 0, 12);
      run_check("div0", 12, 0, 0);
      do_stop();
      set_cfg(0, 1, 128, 1, 0);
      do_start();
      build_model(0, 1, 128, 128, 1, 0, 12);
      run_check("div1", 12, 0, 0);
      do_stop();

      // Burst length 0 in single-burst mode gives one period.
      set_cfg(1, 5, 128, 0, 0);
      do_start();
      build_model(1, 5, 128, 128, 0, 0, 10);
      run_check("m1_blen0", 10, 0, 0);

      // Zero duty: silent while busy.
      set_cfg(0, 6, 0, 1, 0);
      do_start();
      build_model(0, 6, 0, 0, 1, 0, 20);
      run_check("duty0", 20, 0, 0);
      do_stop();

      // Asynchronous reset in the middle of a burst.
      set_cfg(1, 4, 128, 3, 0);
      do_start();
      build_model(1, 4, 128, 128, 3, 0, 20);
      run_check("rst_mid", 7, 0, 0);
      chk("rst_pre_beep", 8, bif.beep, m_hi[6]);
      #2 rst_n = 1'b0;
      #1;
      chk_idle("rst_async", 8);
      #3 rst_n = 1'b1;
      @(posedge clk); #1;
      for (int k = 1; k <= 4; k++) begin
         chk_idle("rst_release", k);
         @(posedge clk); #1;
      end

      // Randomized settings.
      for (int it = 0; it < 16; it++) begin
         md = $urandom_range(0, 3);
         dv = $urandom_range(0, 9);
         dt = $urandom_range(0, 255);
         bl = $urandom_range(0, 4);
         gl = $urandom_range(0, 3);
         set_cfg(md, dv, dt, bl, gl);
         do_start();
         build_model(md, dv, dt, dt, bl, gl, 50);
         run_check($sformatf("rand%0d_m%0d_d%0d_u%0d_b%0d_g%0d", it, md, dv, dt, bl, gl), 50, 0, 0);
         do_stop();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/tone_gen.md
Name: tone_gen

Overview:
- Parametrised successor to the fixed 50 % square-wave beeper: programmable-duty tone generator for the buzzer path.
- Adds start/stop control and three modes: continuous, single burst, and repeating burst/gap pattern (alarm beeping).
- Divisor and duty are re-sampled only at period boundaries, so the output is glitch-free. Sits between the clock/alarm control logic and the buzzer pin.

Parameters:
- CNT_W, 32, width of the divisor and the period counter.
- DUTY_W, 8, width of duty; high fraction = duty / 2^DUTY_W.
- LEN_W, 16, width of the burst_len and gap_len period counts.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  single-cycle pulse; latch mode/lengths and begin tone.
- stop  in  1  single-cycle pulse; abort to idle.
- mode  in  2  0 = continuous, 1 = single burst, 2 = repeat burst/gap, 3 = reserved (behaves as 0).
- divnum  in  CNT_W  clk cycles per tone period.
- duty  in  DUTY_W  high-time fraction.
- burst_len  in  LEN_W  tone periods per burst.
- gap_len  in  LEN_W  silent periods per gap (mode 2).
- beep  out  1  tone output, registered.
- busy  out  1  high in TONE or GAP.
- done  out  1  one-cycle pulse at the end of a mode-1 burst.
- period_tick  out  1  one-cycle pulse per completed period while busy.

Behaviour:
- Reset (async, rst_n = 0): state IDLE; cnt, per_cnt, div_l, th_l and all outputs = 0.
- States:
  - IDLE: beep = 0, busy = 0, cnt held at 0.
  - TONE: period counter runs and beep is driven.
  - GAP: period counter runs and beep is forced to 0.
- Start: on a start pulse, latch mode_l, blen_l = max(burst_len, 1) and glen_l = gap_len. Also latch div_l and th_l. Set cnt = 0 and per_cnt = 0, go to TONE, busy = 1 next cycle.
- Start while busy: restarts as above, with no done pulse.
- Stop: on a stop pulse in any state, go to IDLE next cycle; beep = 0 and busy = 0 next cycle, no done. If stop and start occur in the same cycle, stop wins.
- Divisor and threshold:
  - div_l = max(divnum, 2).
  - th_l = (div_l × duty) >> DUTY_W, computed at full CNT_W+DUTY_W width, then truncated to CNT_W.
  - Both are re-latched at every period boundary from the current inputs and used from cnt = 0 of the next period.
- Period counter: cnt counts 0 .. div_l − 1 and wraps to 0. The boundary is cnt == div_l − 1.
- Beep, registered:
  - In TONE: beep = 1 when cnt ≥ div_l − th_l, otherwise 0. The low phase comes first; one-cycle latency from cnt.
  - duty = 0 gives beep constantly 0. duty = 2^(DUTY_W−1) gives exactly div_l/2 high cycles, matching the legacy beeper for even divisors.
  - In GAP and IDLE: beep = 0.
- period_tick: registered, high the cycle after each boundary while busy.
- Transitions at a boundary:
  - TONE with per_cnt == blen_l − 1:
    - mode 0/3: stay in TONE, per_cnt = 0.
    - mode 1: go to IDLE, with done = 1 for one cycle coincident with busy falling.
    - mode 2: go to GAP, unless glen_l == 0, in which case stay in TONE with per_cnt = 0.
  - GAP with per_cnt == glen_l − 1: go to TONE, per_cnt = 0.
  - Otherwise: per_cnt increments.
- Mid-operation input changes: changes to mode, burst_len or gap_len while busy are ignored until the next start.
- Widths: per_cnt is LEN_W bits and never overflows because it is bounded by blen_l/glen_l. cnt never exceeds div_l − 1, even when divnum shrinks, because the new value only takes effect at the wrap.

Test Plan:
- Reset, then start with mode 0, divnum 10, duty 128 -> beep repeats 5 low / 5 high; period_tick every 10 cycles; busy = 1, done never asserted.
- Mode 0, divnum 8, duty 64 -> 6 low / 2 high per period. Change duty to 192 mid-period -> the current period completes 6/2, the next is 2/6.
- Mode 1, divnum 4, duty 128, burst_len 3 -> exactly 3 periods (12 cycles) of tone, then busy falls with a single done pulse and beep stays 0.
- Mode 2, divnum 4, burst_len 2, gap_len 1 -> repeating 8 cycles tone / 4 cycles silent. A stop pulse during GAP -> IDLE next cycle with no done. A start and stop in the same cycle -> stays IDLE.
- Edge values:
  - divnum 0 and 1 -> behave as divnum 2 (1/1 at duty 128).
  - burst_len 0 in mode 1 -> one period, then done.
  - duty 0 -> beep 0 while busy = 1.
- Async reset asserted mid-burst (between edges) -> beep, busy, done and period_tick go to 0 immediately. After release, IDLE until the next start.
